// File: rtl/line_follow_sequencer.sv
// rtl/line_follow_sequencer.sv - start/ramp/follow/search/halt sequencer around the bang-bang line follower
// Optional feature macro: LAST_SIDE_EN (SEARCH spins toward the side the line was last seen on).
module line_follow_sequencer #(
    parameter int LOST_CYCLES   = 1000,
    parameter int SEARCH_CYCLES = 5000,
    parameter int RAMP_DIV      = 16,
    parameter int SEARCH_SPEED  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       sensor_left,
    input  logic       sensor_right,
    input  logic [5:0] target_speed,
    input  logic [7:0] bb_wheel_left,
    input  logic [7:0] bb_wheel_right,
    output logic       bb_enable,
    output logic [5:0] bb_speed,
    output logic [7:0] wheel_left,
    output logic [7:0] wheel_right,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RAMP   = 3'd1,
        S_FOLLOW = 3'd2,
        S_SEARCH = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int LOST_W   = (LOST_CYCLES > 1)   ? $clog2(LOST_CYCLES)   : 1;
    localparam int SEARCH_W = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
    localparam int RAMP_W   = (RAMP_DIV > 1)      ? $clog2(RAMP_DIV)      : 1;

    localparam logic [LOST_W-1:0]   LOST_LAST   = LOST_W'(LOST_CYCLES - 1);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_CYCLES - 1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST   = RAMP_W'(RAMP_DIV - 1);
    localparam logic [7:0]          SPIN_POS    = 8'(SEARCH_SPEED);
    localparam logic [7:0]          SPIN_NEG    = 8'(-SEARCH_SPEED);

    state_t              state_q, state_d;
    logic [5:0]          bb_speed_q, bb_speed_d;
    logic                bb_enable_q, bb_enable_d;
    logic [7:0]          wheel_left_q, wheel_left_d;
    logic [7:0]          wheel_right_q, wheel_right_d;
    logic                fault_q, fault_d;
    logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
    logic [SEARCH_W-1:0] search_cnt_q, search_cnt_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
`ifdef LAST_SIDE_EN
    logic                last_left_q, last_left_d;
`endif

    logic both_low;
    logic any_hit;
    logic driving_next;

    assign both_low = !sensor_left && !sensor_right;
    assign any_hit  = sensor_left || sensor_right;

    always_comb begin
        state_d      = state_q;
        bb_speed_d   = bb_speed_q;
        lost_cnt_d   = lost_cnt_q;
        search_cnt_d = search_cnt_q;
        ramp_cnt_d   = ramp_cnt_q;
`ifdef LAST_SIDE_EN
        last_left_d  = last_left_q;
        if (state_q == S_RAMP || state_q == S_FOLLOW) begin
            if (sensor_left && !sensor_right) begin
                last_left_d = 1'b1;
            end else if (sensor_right && !sensor_left) begin
                last_left_d = 1'b0;
            end
        end
`endif

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d    = S_RAMP;
                    bb_speed_d = 6'd0;
                    lost_cnt_d = '0;
                    ramp_cnt_d = '0;
                end
            end
            S_RAMP: begin
                if (both_low && lost_cnt_q == LOST_LAST) begin
                    state_d      = S_SEARCH;
                    search_cnt_d = '0;
                    lost_cnt_d   = '0;
                end else begin
                    lost_cnt_d = both_low ? lost_cnt_q + LOST_W'(1) : '0;
                    // A target at or below the current speed ends the ramp immediately.
                    if (target_speed <= bb_speed_q) begin
                        bb_speed_d = target_speed;
                        state_d    = S_FOLLOW;
                        lost_cnt_d = '0;
                    end else if (ramp_cnt_q == RAMP_LAST) begin
                        ramp_cnt_d = '0;
                        bb_speed_d = bb_speed_q + 6'd1;
                        if (bb_speed_q + 6'd1 == target_speed) begin
                            state_d    = S_FOLLOW;
                            lost_cnt_d = '0;
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                    end
                end
            end
            S_FOLLOW: begin
                bb_speed_d = target_speed;
                if (both_low) begin
                    if (lost_cnt_q == LOST_LAST) begin
                        state_d      = S_SEARCH;
                        search_cnt_d = '0;
                        lost_cnt_d   = '0;
                    end else begin
                        lost_cnt_d = lost_cnt_q + LOST_W'(1);
                    end
                end else begin
                    lost_cnt_d = '0;
                end
            end
            S_SEARCH: begin
                // A sensor hit outranks the search timeout in the same cycle.
                if (any_hit) begin
                    state_d    = S_RAMP;
                    bb_speed_d = 6'd0;
                    lost_cnt_d = '0;
                    ramp_cnt_d = '0;
                end else if (search_cnt_q == SEARCH_LAST) begin
                    state_d      = S_HALT;
                    search_cnt_d = '0;
                end else begin
                    search_cnt_d = search_cnt_q + SEARCH_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d      = S_IDLE;
            lost_cnt_d   = '0;
            search_cnt_d = '0;
            ramp_cnt_d   = '0;
        end

        // Outputs are registered from the next state so they always agree with state.
        driving_next  = (state_d == S_RAMP) || (state_d == S_FOLLOW);
        bb_enable_d   = driving_next;
        fault_d       = (state_d == S_HALT);
        wheel_left_d  = 8'd0;
        wheel_right_d = 8'd0;
        if (!driving_next) begin
            bb_speed_d = 6'd0;
        end
        if (driving_next) begin
            wheel_left_d  = bb_wheel_left;
            wheel_right_d = bb_wheel_right;
        end else if (state_d == S_SEARCH) begin
`ifdef LAST_SIDE_EN
            wheel_left_d  = last_left_d ? SPIN_NEG : SPIN_POS;
            wheel_right_d = last_left_d ? SPIN_POS : SPIN_NEG;
`else
            wheel_left_d  = SPIN_POS;
            wheel_right_d = SPIN_NEG;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bb_speed_q    <= 6'd0;
            bb_enable_q   <= 1'b0;
            wheel_left_q  <= 8'd0;
            wheel_right_q <= 8'd0;
            fault_q       <= 1'b0;
            lost_cnt_q    <= '0;
            search_cnt_q  <= '0;
            ramp_cnt_q    <= '0;
`ifdef LAST_SIDE_EN
            last_left_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bb_speed_q    <= bb_speed_d;
            bb_enable_q   <= bb_enable_d;
            wheel_left_q  <= wheel_left_d;
            wheel_right_q <= wheel_right_d;
            fault_q       <= fault_d;
            lost_cnt_q    <= lost_cnt_d;
            search_cnt_q  <= search_cnt_d;
            ramp_cnt_q    <= ramp_cnt_d;
`ifdef LAST_SIDE_EN
            last_left_q   <= last_left_d;
`endif
        end
    end

    assign state       = state_q;
    assign bb_speed    = bb_speed_q;
    assign bb_enable   = bb_enable_q;
    assign wheel_left  = wheel_left_q;
    assign wheel_right = wheel_right_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_line_follow_sequencer.sv
// tb/tb_line_follow_sequencer.sv - directed self-checking bench for line_follow_sequencer
module tb_line_follow_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       sensor_left = 1'b1;
    logic       sensor_right = 1'b1;
    logic [5:0] target_speed = 6'd0;
    logic [7:0] bb_wheel_left = 8'd0;
    logic [7:0] bb_wheel_right = 8'd0;
    logic       bb_enable;
    logic [5:0] bb_speed;
    logic [7:0] wheel_left;
    logic [7:0] wheel_right;
    logic [2:0] state;
    logic       fault;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef LAST_SIDE_EN
    localparam int SRCH_LEFT_WL = -20;
    localparam int SRCH_LEFT_WR = 20;
`else
    localparam int SRCH_LEFT_WL = 20;
    localparam int SRCH_LEFT_WR = -20;
`endif

    line_follow_sequencer #(
        .LOST_CYCLES  (4),
        .SEARCH_CYCLES(10),
        .RAMP_DIV     (2),
        .SEARCH_SPEED (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .sensor_left   (sensor_left),
        .sensor_right  (sensor_right),
        .target_speed  (target_speed),
        .bb_wheel_left (bb_wheel_left),
        .bb_wheel_right(bb_wheel_right),
        .bb_enable     (bb_enable),
        .bb_speed      (bb_speed),
        .wheel_left    (wheel_left),
        .wheel_right   (wheel_right),
        .state         (state),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sensors(input logic l, input logic r);
        sensor_left  = l;
        sensor_right = r;
    endtask

    initial begin
        tick();
        check("rst_state", int'(state), 0);
        check("rst_en", int'(bb_enable), 0);
        check("rst_speed", int'(bb_speed), 0);
        check("rst_wl", int'($signed(wheel_left)), 0);
        check("rst_wr", int'($signed(wheel_right)), 0);
        check("rst_fault", int'(fault), 0);
        reset = 1'b0;

        // Ramp 0..6, one step per two clocks, FOLLOW on the 12th clock.
        target_speed   = 6'd6;
        bb_wheel_left  = 8'd7;
        bb_wheel_right = 8'(-7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ramp_entry_state", int'(state), 1);
        check("ramp_entry_speed", int'(bb_speed), 0);
        check("ramp_entry_en", int'(bb_enable), 1);
        check("ramp_entry_wl", int'($signed(wheel_left)), 7);
        for (int k = 1; k <= 12; k++) begin
            bb_wheel_left  = 8'(k * 3);
            bb_wheel_right = 8'(-k);
            tick();
            check("ramp_speed", int'(bb_speed), k / 2);
            check("ramp_state", int'(state), (k == 12) ? 2 : 1);
            check("ramp_wl", int'($signed(wheel_left)), k * 3);
            check("ramp_wr", int'($signed(wheel_right)), -k);
        end

        // Last seen left, then a short gap that must not trip the lost counter.
        set_sensors(1'b1, 1'b0);
        tick();
        set_sensors(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gap3_state", int'(state), 2);
        end
        set_sensors(1'b1, 1'b0);
        tick();
        check("gap_clear_state", int'(state), 2);
        set_sensors(1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("lost_state", int'(state), (k == 4) ? 3 : 2);
        end
        check("search_en", int'(bb_enable), 0);
        check("search_speed", int'(bb_speed), 0);
        check("search_wl", int'($signed(wheel_left)), SRCH_LEFT_WL);
        check("search_wr", int'($signed(wheel_right)), SRCH_LEFT_WR);

        // Reacquire on the 5th search cycle.
        for (int k = 0; k < 4; k++) begin
            tick();
            check("search_hold", int'(state), 3);
        end
        set_sensors(1'b0, 1'b1);
        tick();
        check("reacq_state", int'(state), 1);
        check("reacq_speed", int'(bb_speed), 0);
        check("reacq_en", int'(bb_enable), 1);

        // Lose the line from RAMP, then let SEARCH time out.
        tick();
        set_sensors(1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        check("ramp_lost_state", int'(state), 3);
        check("ramp_lost_wl", int'($signed(wheel_left)), 20);
        check("ramp_lost_wr", int'($signed(wheel_right)), -20);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("timeout_state", int'(state), (k == 10) ? 4 : 3);
        end
        check("halt_fault", int'(fault), 1);
        check("halt_wl", int'($signed(wheel_left)), 0);
        check("halt_wr", int'($signed(wheel_right)), 0);
        check("halt_en", int'(bb_enable), 0);
        set_sensors(1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_fault", int'(fault), 0);

        // target 0 ends RAMP at once; FOLLOW tracks target each cycle.
        target_speed = 6'd0;
        tick();
        check("t0_state", int'(state), 2);
        check("t0_speed", int'(bb_speed), 0);
        target_speed = 6'd40;
        tick();
        check("f40_speed", int'(bb_speed), 40);
        target_speed = 6'd10;
        tick();
        check("f10_speed", int'(bb_speed), 10);
        check("f10_state", int'(state), 2);

        // Ramp to 30 toward 40, then drop target below current speed.
        stop = 1'b1;
        tick();
        check("stop_follow_state", int'(state), 0);
        check("stop_follow_speed", int'(bb_speed), 0);
        stop = 1'b0;
        target_speed = 6'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
        end
        check("r30_speed", int'(bb_speed), 30);
        check("r30_state", int'(state), 1);
        target_speed = 6'd10;
        tick();
        check("rdrop_speed", int'(bb_speed), 10);
        check("rdrop_state", int'(state), 2);

        // stop beats start; stop from SEARCH.
        stop = 1'b1;
        tick();
        start = 1'b1;
        tick();
        check("start_stop_state", int'(state), 0);
        check("start_stop_en", int'(bb_enable), 0);
        stop = 1'b0;
        tick();
        start = 1'b0;
        check("start2_state", int'(state), 1);
        set_sensors(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        check("pre_stop_search", int'(state), 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_search_state", int'(state), 0);
        check("stop_search_wl", int'($signed(wheel_left)), 0);
        check("stop_search_wr", int'($signed(wheel_right)), 0);

        // Asynchronous reset in the middle of RAMP.
        set_sensors(1'b1, 1'b1);
        target_speed   = 6'd20;
        bb_wheel_left  = 8'd9;
        bb_wheel_right = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_speed", int'(bb_speed), 1);
        check("pre_rst_wl", int'($signed(wheel_left)), 9);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_speed", int'(bb_speed), 0);
        check("arst_en", int'(bb_enable), 0);
        check("arst_wl", int'($signed(wheel_left)), 0);
        check("arst_wr", int'($signed(wheel_right)), 0);
        check("arst_fault", int'(fault), 0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
